// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: 24-hour BCD time of day advanced by a prescaled tick.
// Front-panel minute/hour adjust edges take priority over the seconds step.
module bcd_timekeeper #(
  parameter int TICKS_PER_SEC = 200,
  parameter int PW = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [1:0] hr_tens,
  output logic       sec_pulse,
  output logic       carry_day
);

  logic          tick_d;
  logic          min_d;
  logic          hour_d;
  logic          tick_rise;
  logic          min_rise;
  logic          hour_rise;
  logic          adjust;
  logic          sec_en;
  logic [PW-1:0] presc;
  logic          presc_top;
  logic          min_wrap;
  logic          day_wrap;
  logic [3:0]    min_ones_n;
  logic [2:0]    min_tens_n;
  logic [3:0]    hr_ones_n;
  logic [1:0]    hr_tens_n;

  assign tick_rise = tick_in & ~tick_d;
  assign min_rise  = inc_min & ~min_d;
  assign hour_rise = inc_hour & ~hour_d;
  assign adjust    = min_rise | hour_rise;
  assign presc_top = presc == PW'(TICKS_PER_SEC - 1);
  assign sec_en    = run & tick_rise & presc_top;

  assign min_wrap = (min_ones == 4'd9) && (min_tens == 3'd5);
  assign day_wrap = (sec_ones == 4'd9) && (sec_tens == 3'd5) &&
                    min_wrap &&
                    (hr_tens == 2'd2) && (hr_ones == 4'd3);

  // Next minute/hour values are shared by the carry chain and the adjust path.
  always_comb begin
    min_ones_n = min_ones + 4'd1;
    min_tens_n = min_tens;
    if (min_ones == 4'd9) begin
      min_ones_n = 4'd0;
      min_tens_n = (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;
    end
    hr_ones_n = hr_ones + 4'd1;
    hr_tens_n = hr_tens;
    if ((hr_tens == 2'd2) && (hr_ones == 4'd3)) begin
      hr_ones_n = 4'd0;
      hr_tens_n = 2'd0;
    end else if (hr_ones == 4'd9) begin
      hr_ones_n = 4'd0;
      hr_tens_n = hr_tens + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_d    <= 1'b0;
      min_d     <= 1'b0;
      hour_d    <= 1'b0;
      presc     <= '0;
      sec_pulse <= 1'b0;
      carry_day <= 1'b0;
      sec_ones  <= 4'd0;
      sec_tens  <= 3'd0;
      min_ones  <= 4'd0;
      min_tens  <= 3'd0;
      hr_ones   <= 4'd0;
      hr_tens   <= 2'd0;
    end else begin
      tick_d    <= tick_in;
      min_d     <= inc_min;
      hour_d    <= inc_hour;
      sec_pulse <= sec_en & ~adjust;
      carry_day <= sec_en & ~adjust & day_wrap;

      if (min_rise) begin
        presc <= '0;
      end else if (run & tick_rise) begin
        presc <= presc_top ? '0 : presc + PW'(1);
      end

      if (adjust) begin
        if (min_rise) begin
          sec_ones <= 4'd0;
          sec_tens <= 3'd0;
          min_ones <= min_ones_n;
          min_tens <= min_tens_n;
        end
        if (hour_rise) begin
          hr_ones <= hr_ones_n;
          hr_tens <= hr_tens_n;
        end
      end else if (sec_en) begin
        if (sec_ones != 4'd9) begin
          sec_ones <= sec_ones + 4'd1;
        end else begin
          sec_ones <= 4'd0;
          if (sec_tens != 3'd5) begin
            sec_tens <= sec_tens + 3'd1;
          end else begin
            sec_tens <= 3'd0;
            min_ones <= min_ones_n;
            min_tens <= min_tens_n;
            if (min_wrap) begin
              hr_ones <= hr_ones_n;
              hr_tens <= hr_tens_n;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb_bcd_timekeeper: directed vectors plus random stimulus checked every
// cycle against a seconds-of-day reference model.
module tb_bcd_timekeeper;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       run = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic [3:0] hr_ones;
  logic [1:0] hr_tens;
  logic       sec_pulse;
  logic       carry_day;

  bcd_timekeeper #(.TICKS_PER_SEC(TPS), .PW(16)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .run(run),
    .inc_min(inc_min), .inc_hour(inc_hour),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .hr_ones(hr_ones), .hr_tens(hr_tens),
    .sec_pulse(sec_pulse), .carry_day(carry_day)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tod;
    int pres;
    bit pulse;
    bit carry;
    bit td;
    bit md;
    bit hd;
  } model_t;

  model_t mdl;

  function automatic model_t step(model_t s, logic tk, logic rn,
                                  logic im, logic ih);
    model_t n;
    bit tr, mr, hr, sen;
    int h, m, sec;
    n = s;
    tr = tk && !s.td;
    mr = im && !s.md;
    hr = ih && !s.hd;
    sen = rn && tr && (s.pres == TPS - 1);
    n.td = tk;
    n.md = im;
    n.hd = ih;
    n.pulse = 0;
    n.carry = 0;
    h = s.tod / 3600;
    m = (s.tod / 60) % 60;
    sec = s.tod % 60;
    if (mr || hr) begin
      if (mr) begin
        m = (m + 1) % 60;
        sec = 0;
      end
      if (hr) h = (h + 1) % 24;
      n.tod = h * 3600 + m * 60 + sec;
    end else if (sen) begin
      n.tod = (s.tod + 1) % 86400;
      n.pulse = 1;
      n.carry = (n.tod == 0);
    end
    if (mr) n.pres = 0;
    else if (rn && tr) n.pres = (s.pres + 1) % TPS;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= '{default: 0};
    else mdl <= step(mdl, tick_in, run, inc_min, inc_hour);
  end

  int tests = 0;
  int fails = 0;
  int npulse = 0;
  int ncarry = 0;
  int ncoin = 0;

  function automatic int now_hms();
    return (int'(hr_tens) * 10 + int'(hr_ones)) * 10000 +
           (int'(min_tens) * 10 + int'(min_ones)) * 100 +
           int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step_clk();
    int e;
    @(posedge clk);
    #1;
    if (sec_pulse) npulse++;
    if (carry_day) ncarry++;
    if (sec_pulse && carry_day) ncoin++;
    if (!rst) begin
      e = (mdl.tod / 3600) * 10000 + ((mdl.tod / 60) % 60) * 100 +
          mdl.tod % 60;
      chk("model_time", now_hms(), e);
      chk("model_pulses", {30'd0, sec_pulse, carry_day},
          {30'd0, mdl.pulse, mdl.carry});
    end
  endtask

  task automatic rise();
    tick_in = 1'b1;
    repeat (4) step_clk();
    tick_in = 1'b0;
    repeat (4) step_clk();
  endtask

  task automatic press(input logic im, input logic ih);
    inc_min = im;
    inc_hour = ih;
    step_clk();
    inc_min = 1'b0;
    inc_hour = 1'b0;
    step_clk();
  endtask

  task automatic do_reset();
    tick_in = 1'b0;
    inc_min = 1'b0;
    inc_hour = 1'b0;
    rst = 1'b1;
    step_clk();
    step_clk();
    rst = 1'b0;
    step_clk();
  endtask

  task automatic preload(input int hms);
    do_reset();
    run = 1'b1;
    repeat (hms / 10000) press(1'b1, 1'b0 ^ 1'b1 ? 1'b0 : 1'b0);
    repeat (0) step_clk();
  endtask

  task automatic load(input int hms);
    do_reset();
    run = 1'b1;
    repeat (hms / 10000) press(1'b0, 1'b1);
    repeat ((hms / 100) % 100) press(1'b1, 1'b0);
    repeat ((hms % 100) * TPS) rise();
  endtask

  typedef struct {
    int  hms;
    bit  im;
    bit  ih;
    int  exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{125937, 1'b1, 1'b0, 120000};
    vt[1] = '{231005, 1'b0, 1'b1, 1005};
    vt[2] = '{93000,  1'b0, 1'b1, 103000};
    vt[3] = '{190012, 1'b0, 1'b1, 200012};
    vt[4] = '{235910, 1'b1, 1'b1, 0};
    vt[5] = '{50944,  1'b1, 1'b0, 51000};

    do_reset();
    chk("reset_time", now_hms(), 0);
    chk("reset_pulse", int'(sec_pulse), 0);
    chk("reset_carry", int'(carry_day), 0);

    run = 1'b1;
    npulse = 0;
    repeat (3) rise();
    chk("first_3_rises", now_hms(), 0);
    tick_in = 1'b1;
    step_clk();
    chk("first_sec", now_hms(), 1);
    chk("first_pulse_hi", int'(sec_pulse), 1);
    step_clk();
    chk("first_pulse_lo", int'(sec_pulse), 0);
    repeat (2) step_clk();
    tick_in = 1'b0;
    repeat (4) step_clk();
    chk("first_pulse_count", npulse, 1);

    foreach (vt[i]) begin
      load(vt[i].hms);
      chk("vec_load", now_hms(), vt[i].hms);
      press(vt[i].im, vt[i].ih);
      chk("vec_adjust", now_hms(), vt[i].exp);
    end

    load(235958);
    npulse = 0;
    ncarry = 0;
    ncoin = 0;
    repeat (4) rise();
    chk("day_2359_59", now_hms(), 235959);
    chk("no_early_carry", ncarry, 0);
    repeat (4) rise();
    chk("day_rollover", now_hms(), 0);
    chk("carry_count", ncarry, 1);
    chk("carry_coincide", ncoin, 1);
    chk("rollover_pulses", npulse, 2);

    run = 1'b0;
    npulse = 0;
    repeat (12) rise();
    chk("frozen_time", now_hms(), 0);
    chk("frozen_pulses", npulse, 0);
    run = 1'b1;
    repeat (3) rise();
    chk("thaw_3_rises", now_hms(), 0);
    rise();
    chk("thaw_4th_rise", now_hms(), 1);

    load(125937);
    repeat (2) rise();
    inc_min = 1'b1;
    repeat (50) step_clk();
    inc_min = 1'b0;
    step_clk();
    chk("held_min", now_hms(), 120000);
    repeat (3) rise();
    chk("held_min_presc0", now_hms(), 120000);
    rise();
    chk("held_min_next", now_hms(), 120001);

    load(102030);
    repeat (3) rise();
    tick_in = 1'b1;
    inc_min = 1'b1;
    step_clk();
    chk("coinc_time", now_hms(), 102100);
    chk("coinc_pulse", int'(sec_pulse), 0);
    inc_min = 1'b0;
    repeat (3) step_clk();
    tick_in = 1'b0;
    repeat (4) step_clk();
    repeat (3) rise();
    chk("coinc_3_rises", now_hms(), 102100);
    rise();
    chk("coinc_next", now_hms(), 102101);

    load(50607);
    repeat (2) rise();
    rst = 1'b1;
    #1;
    chk("async_reset", now_hms(), 0);
    step_clk();
    rst = 1'b0;
    step_clk();
    repeat (3) rise();
    chk("post_reset_3", now_hms(), 0);
    rise();
    chk("post_reset_4", now_hms(), 1);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      if ($urandom_range(0, 49) == 0) run = ~run;
      inc_min = ($urandom_range(0, 29) == 0);
      inc_hour = ($urandom_range(0, 19) == 0);
      step_clk();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
